axi_sram_bridge_burst: RTL and testbench

Parametrised successor to the team's AXI-to-SRAM bridge: a full AXI3 burst slave (FIXED/INCR/WRAP, 1-16 beats, ID echo) driving one single-port synchronous SRAM. Independent read and write FSMs share the SRAM port through a round-robin arbiter. Sits between the CPU/DMA interconnect and on-chip SRAM.

---
 rtl/axi_sram_bridge_burst.sv | 166 ++++++++++++++++
 tb/tb_axi_sram_bridge_burst.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_bridge_burst.sv
// axi_sram_bridge_burst: AXI3 burst slave (FIXED/INCR/WRAP, 1-16 beats) onto one single-port
// synchronous SRAM; independent read and write FSMs share the port via a round-robin arbiter.
module axi_sram_bridge_burst #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  output logic [BUS_WIDTH-1:0]    ram_addr,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_wen,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  input  logic [BUS_WIDTH-1:0]    m_araddr,
  input  logic [1:0]              m_arburst,
  input  logic [ID_WIDTH-1:0]     m_arid,
  input  logic [3:0]              m_arlen,
  input  logic                    m_arvalid,
  output logic                    m_arready,
  input  logic [BUS_WIDTH-1:0]    m_awaddr,
  input  logic [1:0]              m_awburst,
  input  logic [ID_WIDTH-1:0]     m_awid,
  input  logic [3:0]              m_awlen,
  input  logic                    m_awvalid,
  output logic                    m_awready,
  input  logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_wlast,
  input  logic                    m_wvalid,
  output logic                    m_wready,
  output logic [ID_WIDTH-1:0]     m_bid,
  output logic [1:0]              m_bresp,
  output logic                    m_bvalid,
  input  logic                    m_bready,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic [ID_WIDTH-1:0]     m_rid,
  output logic [1:0]              m_rresp,
  output logic                    m_rlast,
  output logic                    m_rvalid,
  input  logic                    m_rready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BYTES);
  localparam logic [BUS_WIDTH-1:0] ALIGN = ~BUS_WIDTH'(BYTES - 1);
  localparam logic [1:0] R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2, R_DATA = 2'd3;
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [1:0]            r_state, w_state;
  logic [BUS_WIDTH-1:0]  r_addr, w_addr;
  logic [3:0]            r_len, w_len, r_beat, w_beat;
  logic [1:0]            r_burst, w_burst;
  logic                  r_err, w_err;
  logic [ID_WIDTH-1:0]   r_id, w_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  ptr;
  logic                  r_req, w_req, r_gnt, w_gnt;

  // Illegal burst types and non-power-of-two WRAP lengths run as INCR and report SLVERR.
  function automatic logic [1:0] eff_burst(input logic [1:0] b, input logic [3:0] l);
    return (b == B_FIXED || (b == B_WRAP && l inside {4'd1, 4'd3, 4'd7, 4'd15})) ? b : B_INCR;
  endfunction

  function automatic logic [BUS_WIDTH-1:0] next_addr(input logic [BUS_WIDTH-1:0] a,
                                                     input logic [1:0] b, input logic [3:0] l);
    logic [BUS_WIDTH-1:0] inc, mask;
    inc = a + BUS_WIDTH'(BYTES);
    mask = ((BUS_WIDTH'(l) + BUS_WIDTH'(1)) << OFF) - BUS_WIDTH'(1);
    return b == B_FIXED ? a : b == B_WRAP ? (a & ~mask) | (inc & mask) : inc;
  endfunction

  assign r_req = r_state == R_REQ;
  assign w_req = w_state == W_DATA && m_wvalid;
  assign r_gnt = r_req && (!w_req || !ptr);
  assign w_gnt = w_req && (!r_req || ptr);

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) ptr <= 1'b0;
    else if (r_req && w_req) ptr <= ~ptr;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
    end else
      case (r_state)
        R_IDLE: if (m_arvalid) begin
          r_addr  <= m_araddr & ALIGN;
          r_len   <= m_arlen;
          r_beat  <= '0;
          r_id    <= m_arid;
          r_burst <= eff_burst(m_arburst, m_arlen);
          r_err   <= eff_burst(m_arburst, m_arlen) != m_arburst;
          r_state <= R_REQ;
        end
        R_REQ: if (r_gnt) r_state <= R_WAIT;
        R_WAIT: begin
          r_data  <= ram_rdata;
          r_state <= R_DATA;
        end
        default: if (m_rready) begin
          if (r_beat == r_len) r_state <= R_IDLE;
          else begin
            r_beat  <= r_beat + 4'd1;
            r_addr  <= next_addr(r_addr, r_burst, r_len);
            r_state <= R_REQ;
          end
        end
      endcase

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      w_id    <= '0;
    end else
      case (w_state)
        W_IDLE: if (m_awvalid) begin
          w_addr  <= m_awaddr & ALIGN;
          w_len   <= m_awlen;
          w_beat  <= '0;
          w_id    <= m_awid;
          w_burst <= eff_burst(m_awburst, m_awlen);
          w_err   <= eff_burst(m_awburst, m_awlen) != m_awburst;
          w_state <= W_DATA;
        end
        W_DATA: if (w_gnt) begin
          w_beat <= w_beat + 4'd1;
          w_addr <= next_addr(w_addr, w_burst, w_len);
          if (m_wlast) begin
            w_err   <= w_err | (w_beat != w_len);
            w_state <= W_RESP;
          end else if (w_beat == w_len) w_err <= 1'b1;
        end
        W_RESP: if (m_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase

  assign ram_en    = r_gnt | w_gnt;
  assign ram_wen   = w_gnt ? m_wstrb : '0;
  assign ram_wdata = w_gnt ? m_wdata : '0;
  assign ram_addr  = w_gnt ? w_addr : r_addr;
  assign m_arready = r_state == R_IDLE;
  assign m_awready = w_state == W_IDLE;
  assign m_wready  = w_gnt;
  assign m_rvalid  = r_state == R_DATA;
  assign m_rlast   = m_rvalid && r_beat == r_len;
  assign m_rresp   = (m_rvalid && r_err) ? SLVERR : 2'b00;
  assign m_rdata   = r_data;
  assign m_rid     = r_id;
  assign m_bvalid  = w_state == W_RESP;
  assign m_bresp   = (m_bvalid && w_err) ? SLVERR : 2'b00;
  assign m_bid     = w_id;
endmodule

// File: tb/tb_axi_sram_bridge_burst.sv
// tb_axi_sram_bridge_burst: directed bench for axi_sram_bridge_burst with a behavioural
// one-cycle-latency SRAM and a log of every SRAM access.
module tb_axi_sram_bridge_burst;
  logic        aclk = 1'b0, aresetn = 1'b1;
  logic [31:0] ram_addr;
  logic        ram_en;
  logic [7:0]  ram_wen;
  logic [63:0] ram_wdata, ram_rdata;
  logic [31:0] m_araddr = '0, m_awaddr = '0;
  logic [1:0]  m_arburst = '0, m_awburst = '0;
  logic [3:0]  m_arid = '0, m_awid = '0, m_arlen = '0, m_awlen = '0;
  logic        m_arvalid = 1'b0, m_awvalid = 1'b0, m_arready, m_awready;
  logic [63:0] m_wdata = '0, m_rdata;
  logic [7:0]  m_wstrb = '0;
  logic        m_wlast = 1'b0, m_wvalid = 1'b0, m_wready;
  logic [3:0]  m_bid, m_rid;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready = 1'b0, m_rlast, m_rvalid, m_rready = 1'b1;

  int errs = 0, checks = 0, cyc = 0;
  logic [63:0] mem [0:511];
  logic [31:0] la[$];
  logic [7:0]  lw[$];
  int          rd_cyc[$];
  logic [31:0] t4a [12] = '{32'h200, 32'h300, 32'h308, 32'h310, 32'h208, 32'h318,
                            32'h320, 32'h328, 32'h210, 32'h330, 32'h338, 32'h218};

  always #5 aclk = ~aclk;

  axi_sram_bridge_burst dut (
    .aclk(aclk), .aresetn(aresetn),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .m_araddr(m_araddr), .m_arburst(m_arburst), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_awaddr(m_awaddr), .m_awburst(m_awburst), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  function automatic logic [63:0] pat(input int i);
    return {16'hC0DE, i[15:0], i[31:0] * 32'h01010101};
  endfunction

  function automatic logic [63:0] wd(input int k);
    return {32'hBEEF0000 + k[31:0], 32'h12345678};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
    for (int b = 0; b < 8; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      la.push_back(ram_addr);
      lw.push_back(ram_wen);
      if (ram_wen == 8'h00) begin
        ram_rdata <= mem[ram_addr[11:3]];
        rd_cyc.push_back(cyc);
      end else mem[ram_addr[11:3]] <= merge(mem[ram_addr[11:3]], ram_wdata, ram_wen);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input logic [3:0] id);
    int n = 0;
    @(negedge aclk);
    m_araddr = a; m_arlen = l; m_arburst = b; m_arid = id; m_arvalid = 1'b1;
    while (!m_arready && n < 50) begin @(negedge aclk); n++; end
    chk("ar_timeout", 64'(n < 50), 64'(1));
    @(negedge aclk);
    m_arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input logic [3:0] id);
    int n = 0;
    @(negedge aclk);
    m_awaddr = a; m_awlen = l; m_awburst = b; m_awid = id; m_awvalid = 1'b1;
    while (!m_awready && n < 50) begin @(negedge aclk); n++; end
    chk("aw_timeout", 64'(n < 50), 64'(1));
    @(negedge aclk);
    m_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    m_wdata = d; m_wstrb = s; m_wlast = l; m_wvalid = 1'b1;
    #1;
    while (!m_wready && n < 50) begin @(negedge aclk); #1; n++; end
    chk("w_timeout", 64'(n < 50), 64'(1));
    @(negedge aclk);
    m_wvalid = 1'b0;
  endtask

  task automatic r_get(output logic [63:0] d, output logic [3:0] id, output logic [1:0] rs, output logic l);
    int n = 0;
    @(negedge aclk);
    while (!m_rvalid && n < 50) begin @(negedge aclk); n++; end
    chk("r_timeout", 64'(n < 50), 64'(1));
    d = m_rdata; id = m_rid; rs = m_rresp; l = m_rlast;
  endtask

  task automatic b_get(output logic [3:0] id, output logic [1:0] rs);
    int n = 0;
    while (!m_bvalid && n < 50) begin @(negedge aclk); n++; end
    chk("b_timeout", 64'(n < 50), 64'(1));
    id = m_bid; rs = m_bresp; m_bready = 1'b1;
    @(negedge aclk);
    m_bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input logic [3:0] id, input logic [1:0] resp);
    logic [63:0] d;
    logic [3:0] rid;
    logic [1:0] rs;
    logic last;
    ar_send(a, l, b, id);
    for (int k = 0; k <= int'(l); k++) begin
      r_get(d, rid, rs, last);
      chk("rdata", d, pat(int'(a >> 3) + k));
      chk("rid", 64'(rid), 64'(id));
      chk("rresp", 64'(rs), 64'(resp));
      chk("rlast", 64'(last), 64'(k == int'(l)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [3:0] id;
    logic [1:0] rs;
    logic last;
    for (int i = 0; i < 512; i++) mem[i] <= pat(i);
    #1 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_arready", 64'(m_arready), 64'(1));
    chk("rst_awready", 64'(m_awready), 64'(1));
    chk("rst_rvalid", 64'(m_rvalid), 64'(0));
    chk("rst_bvalid", 64'(m_bvalid), 64'(0));
    chk("rst_wready", 64'(m_wready), 64'(0));
    chk("rst_ram_en", 64'(ram_en), 64'(0));
    chk("rst_rdata", m_rdata, 64'(0));
    aresetn = 1'b1;

    la.delete(); lw.delete();
    rd_burst(32'h100, 4'd3, 2'b01, 4'd5, 2'b00);
    chk("t1_n", 64'(la.size()), 64'(4));
    for (int k = 0; k < 4 && k < la.size(); k++) begin
      chk("t1_addr", 64'(la[k]), 64'(32'h100 + 8 * k));
      chk("t1_wen", 64'(lw[k]), 64'(0));
    end

    la.delete(); lw.delete();
    aw_send(32'h118, 4'd3, 2'b10, 4'd9);
    for (int k = 0; k < 4; k++) w_beat(wd(20 + k), 8'hFF, k == 3);
    b_get(id, rs);
    chk("t2_bid", 64'(id), 64'(9));
    chk("t2_bresp", 64'(rs), 64'(0));
    chk("t2_n", 64'(la.size()), 64'(4));
    if (la.size() == 4) begin
      chk("t2_addr0", 64'(la[0]), 64'(32'h118));
      chk("t2_addr1", 64'(la[1]), 64'(32'h100));
      chk("t2_addr2", 64'(la[2]), 64'(32'h108));
      chk("t2_addr3", 64'(la[3]), 64'(32'h110));
      chk("t2_wen", 64'(lw[2]), 64'(8'hFF));
    end
    chk("t2_mem118", mem[35], wd(20));
    chk("t2_mem100", mem[32], wd(21));

    la.delete(); lw.delete();
    aw_send(32'h40, 4'd2, 2'b00, 4'hA);
    w_beat({2{32'h11111111}}, 8'h0F, 1'b0);
    w_beat({2{32'h22222222}}, 8'hF0, 1'b0);
    w_beat({2{32'h33333333}}, 8'h01, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_bvalid_hold", 64'(m_bvalid), 64'(1));
      chk("t3_bid_hold", 64'(m_bid), 64'(4'hA));
      @(negedge aclk);
    end
    b_get(id, rs);
    chk("t3_bresp", 64'(rs), 64'(0));
    chk("t3_bvalid_off", 64'(m_bvalid), 64'(0));
    chk("t3_n", 64'(la.size()), 64'(3));
    if (la.size() == 3) begin
      chk("t3_addr", 64'(la[2]), 64'(32'h40));
      chk("t3_wen0", 64'(lw[0]), 64'(8'h0F));
      chk("t3_wen1", 64'(lw[1]), 64'(8'hF0));
      chk("t3_wen2", 64'(lw[2]), 64'(8'h01));
    end
    chk("t3_mem", mem[8], 64'h22222222_11111133);

    la.delete(); lw.delete(); rd_cyc.delete();
    fork
      rd_burst(32'h200, 4'd3, 2'b01, 4'd3, 2'b00);
      begin : wr_side
        logic [3:0] fid;
        logic [1:0] frs;
        aw_send(32'h300, 4'd7, 2'b01, 4'd6);
        for (int k = 0; k < 8; k++) w_beat(wd(k), 8'hFF, k == 7);
        b_get(fid, frs);
        chk("t4_bid", 64'(fid), 64'(6));
        chk("t4_bresp", 64'(frs), 64'(0));
      end
    join
    chk("t4_n", 64'(la.size()), 64'(12));
    for (int k = 0; k < 12 && k < la.size(); k++) begin
      chk("t4_addr", 64'(la[k]), 64'(t4a[k]));
      chk("t4_wen", 64'(lw[k]), 64'(t4a[k][8] ? 8'hFF : 8'h00));
    end
    if (rd_cyc.size() == 4) chk("t4_span", 64'(rd_cyc[3] - rd_cyc[0]), 64'(11));
    for (int k = 0; k < 8; k++) chk("t4_mem", mem[96 + k], wd(k));

    la.delete(); lw.delete();
    rd_burst(32'h80, 4'd1, 2'b11, 4'd1, 2'b10);
    chk("t5_n", 64'(la.size()), 64'(2));
    if (la.size() == 2) chk("t5_addr1", 64'(la[1]), 64'(32'h88));
    la.delete();
    rd_burst(32'h700, 4'd2, 2'b10, 4'd2, 2'b10);
    if (la.size() == 3) chk("t5_wrapbad_addr", 64'(la[2]), 64'(32'h710));
    la.delete();
    aw_send(32'h500, 4'd3, 2'b01, 4'hB);
    w_beat(wd(40), 8'hFF, 1'b0);
    w_beat(wd(41), 8'hFF, 1'b1);
    b_get(id, rs);
    chk("t5_early_n", 64'(la.size()), 64'(2));
    chk("t5_early_bid", 64'(id), 64'(4'hB));
    chk("t5_early_bresp", 64'(rs), 64'(2'b10));
    la.delete();
    aw_send(32'h600, 4'd0, 2'b01, 4'hC);
    w_beat(wd(50), 8'hFF, 1'b0);
    w_beat(wd(51), 8'hFF, 1'b1);
    b_get(id, rs);
    chk("t5_late_n", 64'(la.size()), 64'(2));
    chk("t5_late_bresp", 64'(rs), 64'(2'b10));

    ar_send(32'h140, 4'd3, 2'b01, 4'd7);
    m_rready = 1'b0;
    r_get(d, id, rs, last);
    chk("t6_rdata", d, pat(40));
    @(negedge aclk);
    chk("t6_rvalid_hold", 64'(m_rvalid), 64'(1));
    chk("t6_rdata_hold", m_rdata, pat(40));
    aresetn = 1'b0;
    #1;
    chk("t6_rvalid", 64'(m_rvalid), 64'(0));
    chk("t6_ram_en", 64'(ram_en), 64'(0));
    chk("t6_arready", 64'(m_arready), 64'(1));
    chk("t6_rlast", 64'(m_rlast), 64'(0));
    la.delete();
    repeat (3) @(negedge aclk);
    chk("t6_no_access", 64'(la.size()), 64'(0));
    aresetn = 1'b1;
    m_rready = 1'b1;
    rd_burst(32'h180, 4'd1, 2'b01, 4'd2, 2'b00);
    chk("t6_after_n", 64'(la.size()), 64'(2));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
